uart_tx_engine: RTL and testbench

//  Parametrised, synthesizable UART transmitter with a small input FIFO. It replaces the fixed
//  8N1, fixed-bit-time bench stimulus task with an RTL engine.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_fifo.sv | 48 ++++
 rtl/uart_tx_engine.sv | 125 ++++++++++++
 tb/tb_uart_tx_engine.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: transmitter/receiver state encoding and parity selectors shared by the UART blocks.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with async active-low reset; a push while full is dropped even if a pop
// happens in the same cycle. DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  assign full = level_q == LW'(DEPTH);
  assign empty = level_q == '0;
  assign level = level_q;
  assign rdata = mem_q[rd_q];
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmitter (start, DATA_BITS LSB first, STOP_BITS stop) fed by a small FIFO.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after the data bits.
module uart_tx_engine #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [LW-1:0]        fifo_level
);
  import uart_pkg::*;
  localparam int CW = $clog2(CLKS_PER_BIT);
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_engine: illegal parameter set");
  end
  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, fifo_data;
  logic tx_q, tx_d, pop, fifo_empty, fifo_full, cnt_last;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_tx_fifo #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata (s_data),
    .pop   (pop),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );
  assign cnt_last = cnt_q == CW'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  // bit_q counts data bits in DATA and stop bits in STOP; a pop always restarts at START
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || cnt_last) ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    unique case (state_q)
      IDLE: pop = ~fifo_empty;
      START: if (cnt_last) state_d = DATA;
      DATA: if (cnt_last) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(DATA_BITS - 1)) begin
          bit_d = '0;
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (cnt_last) state_d = STOP;
`endif
      STOP: if (cnt_last) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 4'(STOP_BITS - 1)) begin
          bit_d = '0;
          state_d = IDLE;
          pop = ~fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      shift_d = fifo_data;
      bit_d = '0;
    end
`ifdef UART_TX_PARITY_EN
    par_d = pop ? (^fifo_data) ^ 1'(PARITY_ODD) : par_q;
`endif
  end
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      START: tx_d = 1'b0;
      DATA: tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end
  assign tx = tx_q;
  assign s_ready = ~fifo_full;
  assign busy = (state_q != IDLE) | (fifo_level != '0);
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: frame-level model (word accept/pop times, bit windows) checked every cycle on an
// 8N1 engine and a 5N2 engine, plus literal waveform expectations; honours UART_TX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_tx_engine;
  localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  int aa [11] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  int b6 [9] = '{0, 1, 1, 0, 0, 1, 0, 1, 1};
`else
  localparam int P = 0;
  int aa [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
  int b6 [8] = '{0, 1, 1, 0, 0, 1, 1, 1};
`endif
  typedef struct {int acc; int pop; logic [8:0] w;} fr_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] d0 = '0;
  logic [4:0] d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic r0, r1, tx0, tx1, b0, b1;
  logic [2:0] l0, l1;
  int total = 0, bad = 0, cyc = 0;
  fr_t fr [2][64];
  int nfr [2];
  int w4 [6] = '{'hA5, 'h3C, 'h81, 'h7E, 'h12, 'hFF};
  always #5 clk = ~clk;
  uart_tx_engine #(.DATA_BITS(8), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s_data(d0), .s_valid(v0), .s_ready(r0), .tx(tx0), .busy(b0), .fifo_level(l0));
  uart_tx_engine #(.DATA_BITS(5), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY_ODD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .s_data(d1), .s_valid(v1), .s_ready(r1), .tx(tx1), .busy(b1), .fifo_level(l1));
  function automatic int dbits(int i); return i == 0 ? 8 : 5; endfunction
  function automatic int sbits(int i); return i == 0 ? 1 : 2; endfunction
  function automatic int flen(int i); return (1 + dbits(i) + P + sbits(i)) * CPB; endfunction
  function automatic int lvl(int i, int e);
    int n = 0;
    for (int k = 0; k < nfr[i]; k++) if (fr[i][k].acc <= e && fr[i][k].pop > e) n++;
    return n;
  endfunction
  function automatic logic frame_bit(int i, logic [8:0] w, int b);
    if (b == 0) return 1'b0;
    if (b <= dbits(i)) return w[b-1];
    if (P == 1 && b == dbits(i) + 1) return (^w) ^ (i == 1);
    return 1'b1;
  endfunction
  // a word popped at edge p owns the line from edge p+1 through edge p+flen
  function automatic logic exp_tx(int i, int e);
    for (int k = 0; k < nfr[i]; k++)
      if (e > fr[i][k].pop && e <= fr[i][k].pop + flen(i)) return frame_bit(i, fr[i][k].w, (e - fr[i][k].pop - 1) / CPB);
    return 1'b1;
  endfunction
  function automatic logic exp_busy(int i, int e);
    if (lvl(i, e) > 0) return 1'b1;
    for (int k = 0; k < nfr[i]; k++) if (e >= fr[i][k].pop && e < fr[i][k].pop + flen(i)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask
  task automatic at_edge(int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(int i, int data, output int n);
    if (i == 0) begin d0 = data[7:0]; v0 = 1'b1; end
    else begin d1 = data[4:0]; v1 = 1'b1; end
    n = cyc + 1;
    at_edge(n);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask
  always @(posedge clk) begin
    int last;
    cyc = cyc + 1;
    if (!rst_n) nfr = '{0, 0};
    else for (int i = 0; i < 2; i++) begin
      if ((i == 0 ? v0 : v1) && lvl(i, cyc - 1) < 4) begin
        last = nfr[i] == 0 ? 0 : fr[i][nfr[i]-1].pop + flen(i);
        fr[i][nfr[i]].acc = cyc;
        fr[i][nfr[i]].pop = (cyc + 1 > last) ? cyc + 1 : last;
        fr[i][nfr[i]].w = (i == 0) ? {1'b0, d0} : {4'b0, d1};
        nfr[i]++;
      end
    end
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int el;
      logic et, eb;
      el = rst_n ? lvl(i, cyc) : 0;
      et = rst_n ? exp_tx(i, cyc) : 1'b1;
      eb = rst_n ? exp_busy(i, cyc) : 1'b0;
      chk($sformatf("tx[%0d]", i), i == 0 ? tx0 : tx1, et);
      chk($sformatf("busy[%0d]", i), i == 0 ? b0 : b1, eb);
      chk($sformatf("level[%0d]", i), i == 0 ? l0 : l1, el);
      chk($sformatf("ready[%0d]", i), i == 0 ? r0 : r1, el < 4);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int n, base;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx0, 1);
    chk("rst_level", l0, 0);
    chk("rst_ready", r0, 1);
    chk("rst_busy", b0, 0);
    rst_n = 1'b1;
    at_edge(cyc + 3);
    send(0, 'hAA, n);
    at_edge(n + 1); chk("t1_pre_start", tx0, 1);
    at_edge(n + 2); chk("t1_start_fall", tx0, 0);
    for (int b = 0; b < $size(aa); b++) begin
      at_edge(n + 2 + CPB * b + 4);
      chk($sformatf("t1_bit%0d", b), tx0, aa[b]);
    end
    at_edge(n + flen(0)); chk("t1_busy_last", b0, 1);
    at_edge(n + flen(0) + 1); chk("t1_busy_off", b0, 0);
    at_edge(cyc + 5);
    d0 = 8'h55; v0 = 1'b1; n = cyc + 1;
    at_edge(n); d0 = 8'h0F;
    at_edge(n + 1); v0 = 1'b0;
    at_edge(n + 1 + flen(0)); chk("t3_last_stop", tx0, 1);
    at_edge(n + 2 + flen(0)); chk("t3_second_start", tx0, 0);
    at_edge(n + 2 * flen(0) + 10);
    base = nfr[0];
    d0 = w4[0][7:0]; v0 = 1'b1; n = cyc + 1;
    for (int k = 1; k < 6; k++) begin
      at_edge(n + k - 1);
      d0 = w4[k][7:0];
    end
    chk("t4_level_full", l0, 4);
    chk("t4_ready_low", r0, 0);
    at_edge(n + 5); v0 = 1'b0;
    chk("t4_level_held", l0, 4);
    chk("t4_accepted", nfr[0] - base, 5);
    at_edge(n + 6 * flen(0));
    d0 = 8'hF0; v0 = 1'b1; n = cyc + 1;
    at_edge(n); d0 = 8'h33;
    at_edge(n + 1); v0 = 1'b0;
    at_edge(n + 2 + CPB * 4 + 3);
    chk("t5_bit3", tx0, 0);
    chk("t5_queued", l0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", tx0, 1);
    chk("t5_rst_level", l0, 0);
    chk("t5_rst_busy", b0, 0);
    at_edge(cyc + 2);
    rst_n = 1'b1;
    at_edge(cyc + 100); chk("t5_idle_after", tx0, 1);
    send(1, 'h13, n);
    for (int b = 0; b < $size(b6); b++) begin
      at_edge(n + 2 + CPB * b + 4);
      chk($sformatf("t6_bit%0d", b), tx1, b6[b]);
    end
    at_edge(n + flen(1)); chk("t6_busy_last", b1, 1);
    at_edge(n + flen(1) + 1); chk("t6_busy_off", b1, 0);
    at_edge(cyc + 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
